// File: rtl/bin2bcd_serial_pkg.sv
// rtl/bin2bcd_serial_pkg.sv - shared FSM encodings and BCD constants for bin2bcd_serial
package bin2bcd_serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int         BCD_NIB     = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    // Counter must be able to hold DATA_W itself.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_serial_add3.sv
// rtl/bin2bcd_serial_add3.sv - double-dabble digit correction, one BCD nibble
module bcd_add3
    import bin2bcd_serial_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= ADD3_THRESH) ? din + ADD3_VAL : din;

endmodule

// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - serial shift-add-3 binary to BCD converter; BIN2BCD_LZB_EN adds digit_en
module bin2bcd_serial
    import bin2bcd_serial_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_LZB_EN
    ,
    output logic [DIGITS-1:0]     digit_en
`endif
);

    localparam int BCD_W = BCD_NIB * DIGITS;
    localparam int CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] bin_sr;
    logic [BCD_W-1:0]  bcd_sr;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_sr[g*BCD_NIB +: BCD_NIB]),
            .dout (bcd_adj[g*BCD_NIB +: BCD_NIB])
        );
    end

    // Corrected digits shifted left with the next binary MSB entering the units digit.
    assign bcd_next = {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};

`ifdef BIN2BCD_LZB_EN
    function automatic logic [DIGITS-1:0] lzb_mask(input logic [BCD_W-1:0] b);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen = seen | (|b[i*BCD_NIB +: BCD_NIB]);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
`ifdef BIN2BCD_LZB_EN
            digit_en <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr <= bin_in;
                        bcd_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_sr <= bcd_next;
                    bin_sr <= {bin_sr[DATA_W-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        bcd_out  <= bcd_next;
`ifdef BIN2BCD_LZB_EN
                        digit_en <= lzb_mask(bcd_next);
`endif
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// tb/tb_bin2bcd_serial.sv - randomized self-checking bench for bin2bcd_serial
module tb_bin2bcd_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] bin_in;
    logic        busy;
    logic        done;
    logic [39:0] bcd_out;
`ifdef BIN2BCD_LZB_EN
    logic [9:0]  digit_en;
`endif

    int errors = 0;
    int checks = 0;

    bin2bcd_serial #(.DATA_W(32), .DIGITS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out)
`ifdef BIN2BCD_LZB_EN
        ,
        .digit_en (digit_en)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by repeated division, units first.
    function automatic logic [39:0] ref_bcd(input logic [31:0] v);
        logic [39:0] r;
        longint      x;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < 10; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [9:0] ref_en(input logic [31:0] v);
        logic [9:0] m;
        longint     p;
        m = '0;
        p = 1;
        for (int i = 0; i < 10; i++) begin
            m[i] = (i == 0) || (longint'(v) >= p);
            p = p * 10;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_conv(input string tag, input logic [31:0] v);
        int lat;
        int busy_cyc;
        start  = 1'b1;
        bin_in = v;
        tick();
        start  = 1'b0;
        bin_in = $urandom;
        busy_cyc = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (busy) busy_cyc++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd32);
        check({tag, "_busy"}, 64'(busy_cyc), 64'd32);
        check({tag, "_bcd"}, 64'(bcd_out), 64'(ref_bcd(v)));
`ifdef BIN2BCD_LZB_EN
        check({tag, "_en"}, 64'(digit_en), 64'(ref_en(v)));
`endif
        tick();
        check({tag, "_done_1cyc"}, 64'(done), 64'd0);
        check({tag, "_hold"}, 64'(bcd_out), 64'(ref_bcd(v)));
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] v;

        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd", 64'(bcd_out), 64'd0);
`ifdef BIN2BCD_LZB_EN
        check("rst_en", 64'(digit_en), 64'd0);
`endif
        rst = 1'b0;
        tick();

        run_conv("t1", 32'd2015036580);
        check("t1_const", 64'(bcd_out), 64'h20_1503_6580);
        run_conv("zero", 32'd0);
        run_conv("max", 32'hFFFF_FFFF);
        check("max_const", 64'(bcd_out), 64'h42_9496_7295);
        run_conv("b42", 32'd42);

        // start while busy must be ignored
        start  = 1'b1;
        bin_in = 32'd99;
        tick();
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 10) begin
                start  = 1'b1;
                bin_in = 32'd7;
            end else begin
                start  = 1'b0;
            end
            tick();
            if (done) pulses++;
        end
        start = 1'b0;
        check("busy_start_pulses", 64'(pulses), 64'd1);
        check("busy_start_bcd", 64'(bcd_out), 64'h99);

        // reset mid-conversion
        start  = 1'b1;
        bin_in = 32'd123456;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_bcd", 64'(bcd_out), 64'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_pulses", 64'(pulses), 64'd0);
        check("abort_bcd_hold", 64'(bcd_out), 64'd0);
        run_conv("after_rst", 32'd5);

        // back-to-back: next start accepted in the done cycle
        start  = 1'b1;
        bin_in = 32'd31337;
        tick();
        start  = 1'b0;
        wait_done(lat);
        check("b2b_first", 64'(bcd_out), 64'(ref_bcd(32'd31337)));
        start  = 1'b1;
        bin_in = 32'd42;
        tick();
        start  = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check("b2b_gap", 64'(lat), 64'd33);
        check("b2b_bcd", 64'(bcd_out), 64'h42);
        tick();

        for (int n = 0; n < 24; n++) begin
            case (n % 3)
                0:       v = $urandom;
                1:       v = 32'($urandom_range(0, 999));
                default: v = $urandom >> $urandom_range(0, 31);
            endcase
            run_conv("rand", v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
